twiddle_gen: RTL
================

Name: twiddle_gen

Overview:
- Parametrised twiddle-factor generator for the radix-2 pipelined FFT/IFFT. It replaces the separate full-length real/imag ROM pair with a single quarter-wave cosine table plus symmetry folding.
- Computes W_N^k = cos(2πk/N) − j·sin(2πk/N) for any pipeline stage from a per-stage index.
- Supports conjugation for IFFT and a clock-enable freeze.
- Sits beside each butterfly stage and feeds the complex multiplier.

Parameters:
- WIDTH, 16, output sample width, signed Q1.(WIDTH−1).
- LOGN, 6, log2 of FFT length N; must be ≥ 3.
- STW, 3, width of stage input; 2^STW ≥ LOGN.
- INIT_FILE, "wn_quarter.hex", $readmemh image holding C[m] for m = 0..N/4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  pipeline clock enable; 0 freezes every register.
- in_valid  in  1  request strobe.
- idx  in  LOGN−1  butterfly index within the stage.
- stage  in  STW  stage number s; twiddle exponent k = (idx << s) mod N/2.
- inv  in  1  1 = IFFT (conjugate output).
- wn_re  out  WIDTH  real part, signed.
- wn_im  out  WIDTH  imaginary part, signed.
- out_valid  out  1  wn_re/wn_im valid.

Behaviour:
- Table storage:
  - C has N/4+1 entries, each WIDTH bits, loaded from INIT_FILE at elaboration.
  - C[m] = round(cos(2πm/N)·2^(WIDTH−1)), saturated to 2^(WIDTH−1)−1 (MAX); C[N/4] = 0.
  - The table is read through two independent synchronous read ports (A, B).
- Fold rules, with Q = N/4 and k of width LOGN−1:
  - k ≤ Q: addrA = k, addrB = Q−k, negA = 0, negB = 1.
  - k > Q: addrA = N/2−k, addrB = k−Q, negA = 1, negB = 1.
  - Result: re = ±C[addrA] using negA; im = ±C[addrB] using negB.
  - inv = 1 inverts negB.
  - Negation is two's complement; no overflow is possible because |C| ≤ MAX.
- Pipeline (3 registered stages, all gated by ce):
  - S1: compute k; register addrA, addrB, negA, negB and valid.
  - S2: ROM read; register data and the flags.
  - S3: apply signs; register wn_re, wn_im, out_valid.
- Latency: exactly 3 ce-enabled cycles from in_valid to out_valid. Throughput is 1 request per enabled cycle.
- in_valid = 0 still advances the pipe; out_valid follows the delayed in_valid. Data outputs hold their last values when out_valid = 0 (no zeroing).
- ce = 0 holds all state, including out_valid. Requests presented while ce = 0 are ignored.
- Shift overflow: bits of idx << s beyond LOGN−2 are discarded. A stage value s ≥ LOGN−1 therefore yields k = 0 (W = 1).
- Reset (asynchronous, rst_n = 0):
  - Clears all pipeline registers; wn_re = 0, wn_im = 0, out_valid = 0.
  - Reset mid-stream drops every in-flight request. The first valid output after release appears 3 enabled cycles after the next in_valid.
- Boundaries:
  - k = 0 → (MAX, 0).
  - k = Q → (0, −MAX), or (0, +MAX) when inv = 1.
  - k = N/2−1 uses addrA = 1 and addrB = Q−1.
  - ±0 results must be exactly 0.

Test Plan:
- LOGN=6, WIDTH=16: reset, then idx=0, s=0, inv=0 → 3 cycles later out_valid=1, wn_re=32767, wn_im=0. During and just after reset all outputs are 0.
- idx=8, s=0 → (23170, −23170); idx=16 → (0, −32767); idx=24 → (−23170, −23170); idx=31 → (−32610, −3212).
- idx=4, s=1 and idx=2, s=2 both give k=8 → (23170, −23170). idx=20, s=1 gives k=40 mod 32 = 8 → same result. s=5 with any idx → (32767, 0).
- inv=1, idx=8, s=0 → (23170, +23170); inv=1, idx=16 → (0, +32767).
- Back-to-back stream idx=0..31 with in_valid=1 and ce toggling 1,1,0,1: outputs appear in order and no sample is dropped or duplicated. out_valid is held during ce=0 cycles.
- Assert rst_n=0 with 2 requests in flight → out_valid=0 immediately (asynchronous). After release, no stale output appears.

Source files
------------

// File: rtl/twiddle_gen.sv
// Twiddle-factor generator for the radix-2 pipelined FFT/IFFT.
// Produces W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) from a quarter-wave cosine
// table C[0..N/4] folded by symmetry. The table is read through two synchronous
// ports: port A supplies |re| and port B supplies |im|.
// Signs are applied in the last stage, and inv conjugates the output for IFFT.
// The table image is built at elaboration from the same rounding rule used to
// produce wn_quarter.hex, C[m] = round(cos(2*pi*m/N) * 2^(WIDTH-1)) saturated
// to 2^(WIDTH-1)-1, so the block needs no file at simulation or synthesis time.
// INIT_FILE is kept only so existing instantiations stay drop-in compatible.
module twiddle_gen #(
    parameter int WIDTH     = 16,
    parameter int LOGN      = 6,
    parameter int STW       = 3,
    parameter     INIT_FILE = "wn_quarter.hex"
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic [LOGN-2:0]         idx,
    input  logic [STW-1:0]          stage,
    input  logic                    inv,
    output logic signed [WIDTH-1:0] wn_re,
    output logic signed [WIDTH-1:0] wn_im,
    output logic                    out_valid
);

    localparam int unsigned N      = 1 << LOGN;
    localparam int unsigned Q      = N / 4;
    localparam int          KW     = LOGN - 1;
    localparam int          MAXV   = (1 << (WIDTH - 1)) - 1;
    localparam real         TWO_PI = 6.283185307179586;
    localparam logic [31:0] Q_WORD = 32'(Q);
    localparam logic [KW-1:0] Q_K  = Q_WORD[KW-1:0];

    // Quarter-wave cosine table, entry m at bits [m*WIDTH +: WIDTH].
    function automatic logic [(Q+1)*WIDTH-1:0] build_table();
        logic [(Q+1)*WIDTH-1:0] t;
        real scale;
        real v;
        int  r;
        t     = '0;
        scale = 2.0 ** (WIDTH - 1);
        for (int unsigned m = 0; m <= Q; m++) begin
            v = $cos(TWO_PI * real'(m) / real'(N)) * scale;
            r = $rtoi(v + 0.5);
            if (r > MAXV) r = MAXV;
            // cos(pi/2) is exactly zero; guard against floating residue
            if (m == Q) r = 0;
            t[m*WIDTH +: WIDTH] = r[WIDTH-1:0];
        end
        return t;
    endfunction

    localparam logic [(Q+1)*WIDTH-1:0] TABLE = build_table();

    // Stage-1 combinational fold
    logic [KW-1:0] k;
    logic [KW-1:0] fold_addr_a;
    logic [KW-1:0] fold_addr_b;
    logic          fold_neg_a;
    logic          fold_neg_b;

    // Stage 1 registers
    logic          s1_valid;
    logic [KW-1:0] s1_addr_a;
    logic [KW-1:0] s1_addr_b;
    logic          s1_neg_a;
    logic          s1_neg_b;

    // Stage 2 registers
    logic                    s2_valid;
    logic signed [WIDTH-1:0] s2_data_a;
    logic signed [WIDTH-1:0] s2_data_b;
    logic                    s2_neg_a;
    logic                    s2_neg_b;

    // Shift bits above LOGN-2 fall off, so a large stage collapses k to 0.
    assign k = idx << stage;

    // Map k onto the quarter table: first quarter direct, second quarter mirrored.
    always_comb begin
        fold_addr_a = k;
        fold_addr_b = Q_K - k;
        fold_neg_a  = 1'b0;
        fold_neg_b  = 1'b1;
        if (k > Q_K) begin
            // N/2 - k, taken modulo 2^KW where N/2 == 2^KW
            fold_addr_a = '0 - k;
            fold_addr_b = k - Q_K;
            fold_neg_a  = 1'b1;
        end
        fold_neg_b = fold_neg_b ^ inv;
    end

    // Stage 1: register folded addresses, sign flags and request strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_addr_a <= '0;
            s1_addr_b <= '0;
            s1_neg_a  <= 1'b0;
            s1_neg_b  <= 1'b0;
        end else if (ce) begin
            s1_valid  <= in_valid;
            s1_addr_a <= fold_addr_a;
            s1_addr_b <= fold_addr_b;
            s1_neg_a  <= fold_neg_a;
            s1_neg_b  <= fold_neg_b;
        end
    end

    // Stage 2: two synchronous table reads, flags carried alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_data_a <= '0;
            s2_data_b <= '0;
            s2_neg_a  <= 1'b0;
            s2_neg_b  <= 1'b0;
        end else if (ce) begin
            s2_valid  <= s1_valid;
            s2_data_a <= TABLE[int'(s1_addr_a) * WIDTH +: WIDTH];
            s2_data_b <= TABLE[int'(s1_addr_b) * WIDTH +: WIDTH];
            s2_neg_a  <= s1_neg_a;
            s2_neg_b  <= s1_neg_b;
        end
    end

    // Stage 3: apply signs; |C| <= MAX so negation never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            wn_re     <= '0;
            wn_im     <= '0;
        end else if (ce) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                wn_re <= s2_neg_a ? -s2_data_a : s2_data_a;
                wn_im <= s2_neg_b ? -s2_data_b : s2_data_b;
            end
        end
    end

endmodule
